// File: rtl/param_mem_controller.sv
// Byte-enabled word memory cleared at reset, with an in-order read-response buffer.
// Reads respond RD_LAT cycles after accept; read accepts are credit-limited, writes never stall in RUN.
module param_mem_controller #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 1024,
    parameter int RD_LAT    = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [31:0]         req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_err,
    output logic                wr_err,
    output logic                init_done
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW = DATA_W / 8;
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t              r_state;
    logic [AW-1:0]       r_init_addr;
    logic                r_wr_err;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [CW-1:0]       r_credit_cnt;
    logic [RD_LAT-1:0]   r_p_vld;
    logic [RD_LAT-1:0]   r_p_err;
    logic [DATA_W-1:0]   r_p_dat [RD_LAT];
    logic [CW-1:0]       r_fcnt;
    logic [DATA_W-1:0]   r_b_dat [RSP_DEPTH];
    logic [RSP_DEPTH-1:0] r_b_err;

    logic              w_run;
    logic              w_in_range;
    logic [AW-1:0]     w_idx;
    logic              w_acc;
    logic              w_acc_rd;
    logic              w_acc_wr;
    logic [DATA_W-1:0] w_rd_dat;
    logic              w_head_vld;
    logic              w_pipe_vld;
    logic              w_pop;
    logic              w_shift;
    logic              w_push;
    logic [CW-1:0]     w_wpos;

    assign w_run      = (r_state == RUN);
    assign w_in_range = (req_addr < 32'(DEPTH));
    assign w_idx      = req_addr[AW-1:0];
    // r_credit_cnt covers reads still in the pipeline plus those already buffered
    assign req_ready  = w_run && (req_we || (r_credit_cnt < CW'(RSP_DEPTH)));
    assign w_acc      = req_valid && req_ready;
    assign w_acc_rd   = w_acc && !req_we;
    assign w_acc_wr   = w_acc && req_we;
    assign w_rd_dat   = w_in_range ? r_mem[w_idx] : '0;

    // The last pipeline stage is presented directly when the buffer is empty
    assign w_head_vld = (r_fcnt != '0);
    assign w_pipe_vld = r_p_vld[RD_LAT-1];
    assign rsp_valid  = w_head_vld || w_pipe_vld;
    assign rsp_data   = w_head_vld ? r_b_dat[0] : (w_pipe_vld ? r_p_dat[RD_LAT-1] : '0);
    assign rsp_err    = w_head_vld ? r_b_err[0] : (w_pipe_vld && r_p_err[RD_LAT-1]);
    assign w_pop      = rsp_valid && rsp_ready;
    assign w_shift    = w_pop && w_head_vld;
    assign w_push     = w_pipe_vld && !(w_pop && !w_head_vld);
    assign w_wpos     = r_fcnt - CW'(w_shift);

    assign wr_err    = r_wr_err;
    assign init_done = w_run;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= INIT;
            r_init_addr  <= '0;
            r_wr_err     <= 1'b0;
            r_credit_cnt <= '0;
            r_p_vld      <= '0;
            r_p_err      <= '0;
            r_fcnt       <= '0;
        end else begin
            r_wr_err <= w_acc_wr && !w_in_range;
            if (r_state == INIT) begin
                r_init_addr <= r_init_addr + AW'(1);
                if (r_init_addr == LAST_ADDR) begin
                    r_state <= RUN;
                end
            end
            r_credit_cnt <= r_credit_cnt + CW'(w_acc_rd) - CW'(w_pop);
            r_p_vld[0]   <= w_acc_rd;
            r_p_err[0]   <= w_acc_rd && !w_in_range;
            for (int k = 1; k < RD_LAT; k++) begin
                r_p_vld[k] <= r_p_vld[k-1];
                r_p_err[k] <= r_p_err[k-1];
            end
            r_fcnt <= r_fcnt - CW'(w_shift) + CW'(w_push);
        end
    end

    always_ff @(posedge clk) begin
        r_p_dat[0] <= w_rd_dat;
        for (int k = 1; k < RD_LAT; k++) begin
            r_p_dat[k] <= r_p_dat[k-1];
        end
        if (w_shift) begin
            for (int i = 0; i < RSP_DEPTH - 1; i++) begin
                r_b_dat[i] <= r_b_dat[i+1];
                r_b_err[i] <= r_b_err[i+1];
            end
        end
        if (w_push) begin
            r_b_dat[w_wpos] <= r_p_dat[RD_LAT-1];
            r_b_err[w_wpos] <= r_p_err[RD_LAT-1];
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == INIT) begin
            r_mem[r_init_addr] <= '0;
        end else if (w_acc_wr && w_in_range) begin
            for (int b = 0; b < BW; b++) begin
                if (req_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_param_mem_controller.sv
// Directed and randomized checks of param_mem_controller against a queue-based reference model.
module tb_param_mem_controller;
    localparam int DATA_W    = 32;
    localparam int DEPTH     = 16;
    localparam int RD_LAT    = 2;
    localparam int RSP_DEPTH = 4;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                req_valid = 1'b0;
    logic                req_we = 1'b0;
    logic [31:0]         req_addr = '0;
    logic [DATA_W-1:0]   req_wdata = '0;
    logic [DATA_W/8-1:0] req_be = '0;
    logic                rsp_ready = 1'b0;
    logic                req_ready, rsp_valid, rsp_err, wr_err, init_done;
    logic [DATA_W-1:0]   rsp_data;

    param_mem_controller #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .wr_err(wr_err), .init_done(init_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              e;
        int                t;
    } rsp_t;

    rsp_t              mq[$];
    logic [DATA_W-1:0] mmem [DEPTH];
    bit                m_run = 1'b0;
    int                m_init = 0;
    bit                m_wr_err = 1'b0;
    int                now = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, now);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_run    = 1'b0;
        m_init   = 0;
        m_wr_err = 1'b0;
    endfunction

    // One clock cycle: compare outputs mid-cycle, then advance the model at the edge.
    task automatic cyc(output bit acc_dut);
        bit   er, ev, acc, pop;
        rsp_t r;
        @(negedge clk);
        er = !reset && m_run && (req_we || mq.size() < RSP_DEPTH);
        ev = !reset && mq.size() > 0 && mq[0].t <= now;
        chk("req_ready", req_ready, er);
        chk("rsp_valid", rsp_valid, ev);
        chk("init_done", init_done, !reset && m_run);
        chk("wr_err", wr_err, !reset && m_wr_err);
        if (ev) begin
            chk("rsp_data", rsp_data, mq[0].d);
            chk("rsp_err", rsp_err, mq[0].e);
        end
        acc_dut = req_valid && req_ready;
        acc = req_valid && er;
        pop = ev && rsp_ready;
        @(posedge clk);
        now++;
        if (reset) begin
            model_reset();
        end else begin
            m_wr_err = acc && req_we && (req_addr >= DEPTH);
            if (pop) void'(mq.pop_front());
            if (acc && req_we && req_addr < DEPTH) begin
                for (int b = 0; b < DATA_W/8; b++)
                    if (req_be[b]) mmem[int'(req_addr)][8*b +: 8] = req_wdata[8*b +: 8];
            end
            if (acc && !req_we) begin
                r.e = (req_addr >= DEPTH);
                r.d = r.e ? '0 : mmem[int'(req_addr)];
                r.t = now - 1 + RD_LAT;
                mq.push_back(r);
            end
            if (!m_run) begin
                m_init++;
                if (m_init == DEPTH) begin
                    m_run = 1'b1;
                    foreach (mmem[i]) mmem[i] = '0;
                end
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        req_valid = 1'b0;
        repeat (n) cyc(a);
    endtask

    task automatic do_reset(input int hold);
        bit a;
        reset = 1'b1;
        req_valid = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, '0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_wr_err", wr_err, 1'b0);
        chk("rst_init_done", init_done, 1'b0);
        model_reset();
        repeat (hold) cyc(a);
        reset = 1'b0;
    endtask

    task automatic wait_init();
        bit a;
        int k = 0;
        req_valid = 1'b0;
        while (!init_done && k < 100) begin
            cyc(a);
            k++;
        end
        chk("init_latency", k, DEPTH);
    endtask

    task automatic issue(input bit we, input logic [31:0] addr,
                         input logic [DATA_W-1:0] data, input logic [DATA_W/8-1:0] be);
        bit a = 1'b0;
        int k = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        req_be    = be;
        while (!a && k < 50) begin
            cyc(a);
            k++;
        end
        chk("accept", a, 1'b1);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        bit a;
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        while (mq.size() > 0 && k < 100) begin
            cyc(a);
            k++;
        end
        cyc(a);
    endtask

    initial begin
        bit a;
        int nacc;
        @(posedge clk);
        #1;
        do_reset(3);
        wait_init();

        // every location reads back zero after the clear
        rsp_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) issue(1'b0, i, '0, '0);
        drain();

        // byte-enable merge and read-after-write, with exact response latency
        issue(1'b1, 5, 32'hDEADBEEF, 4'hF);
        issue(1'b1, 5, 32'h000000AA, 4'h1);
        issue(1'b0, 5, '0, '0);
        chk("lat_early", rsp_valid, 1'b0);
        cyc(a);
        chk("lat_vld", rsp_valid, 1'b1);
        chk("lat_dat", rsp_data, 32'hDEADBEAA);
        drain();

        // out-of-range read and write; 2000 aliases address 0 in the low bits
        issue(1'b0, DEPTH, '0, '0);
        issue(1'b0, 1024, '0, '0);
        issue(1'b1, 2000, 32'hFFFFFFFF, 4'hF);
        chk("wr_err_pulse", wr_err, 1'b1);
        cyc(a);
        chk("wr_err_clear", wr_err, 1'b0);
        issue(1'b0, 0, '0, '0);
        issue(1'b0, DEPTH - 1, '0, '0);
        drain();

        // credit limit with the consumer stalled
        for (int i = 0; i < 6; i++) issue(1'b1, i, 32'h100 + i, 4'hF);
        rsp_ready = 1'b0;
        req_we = 1'b0;
        nacc = 0;
        for (int c = 0; c < 12; c++) begin
            req_addr  = nacc;
            req_valid = (nacc < 6);
            cyc(a);
            if (a) nacc++;
        end
        chk("credit_accepted", nacc, RSP_DEPTH);
        chk("credit_ready_low", req_ready, 1'b0);
        issue(1'b1, 7, 32'h777, 4'hF);
        rsp_ready = 1'b1;
        issue(1'b0, 4, '0, '0);
        issue(1'b0, 5, '0, '0);
        drain();

        // reset in the middle of the clear
        do_reset(2);
        idle(5);
        do_reset(2);
        wait_init();

        // reset with buffered responses and one read in flight
        issue(1'b1, 1, 32'h11111111, 4'hF);
        issue(1'b1, 2, 32'h22222222, 4'hF);
        rsp_ready = 1'b0;
        issue(1'b0, 1, '0, '0);
        issue(1'b0, 2, '0, '0);
        issue(1'b0, 3, '0, '0);
        idle(3);
        chk("pre_reset_buffered", rsp_valid, 1'b1);
        issue(1'b0, 1, '0, '0);
        do_reset(2);
        wait_init();
        rsp_ready = 1'b1;
        idle(6);
        issue(1'b0, 1, '0, '0);
        issue(1'b0, 2, '0, '0);
        drain();

        // randomized traffic including simultaneous push and pop
        for (int c = 0; c < 400; c++) begin
            req_valid = ($urandom_range(0, 9) < 7);
            req_we    = $urandom_range(0, 1);
            req_addr  = $urandom_range(0, DEPTH + 3);
            req_wdata = $urandom;
            req_be    = $urandom;
            rsp_ready = ($urandom_range(0, 9) < 6);
            cyc(a);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/param_mem_controller.md
PARAM_MEM_CONTROLLER -- requirements
Module: param_mem_controller

Interface
REQ-001 Parameter DATA_W, default 32: data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 1024: number of words; SHALL be 2..65536 and need not be a power of two.
REQ-003 Parameter RD_LAT, default 2: read latency from request accept to response; SHALL be 1..4.
REQ-004 Parameter RSP_DEPTH, default 4: response buffer entries; SHALL be >= RD_LAT.
REQ-005 Port clk, input, 1: sole clock; all logic on the rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Port req_valid, input, 1: request present.
REQ-008 Port req_ready, output, 1: controller accepts a request this cycle.
REQ-009 Port req_we, input, 1: 1 is a write, 0 is a read.
REQ-010 Port req_addr, input, 32: word address.
REQ-011 Port req_wdata, input, DATA_W: write data.
REQ-012 Port req_be, input, DATA_W/8: byte enables for writes; bit i qualifies byte i.
REQ-013 Port rsp_valid, output, 1: read response present.
REQ-014 Port rsp_ready, input, 1: consumer accepts the response.
REQ-015 Port rsp_data, output, DATA_W: read data.
REQ-016 Port rsp_err, output, 1: the response is for an out-of-range address.
REQ-017 Port wr_err, output, 1: one-cycle pulse when an out-of-range write is accepted.
REQ-018 Port init_done, output, 1: memory clear is complete.

Function
REQ-019 A request SHALL be accepted in any cycle where req_valid and req_ready are both 1; at most one request per cycle.
REQ-020 The FSM SHALL have two states, INIT and RUN; reset SHALL enter INIT.
REQ-021 INIT: the FSM SHALL write zero to addresses 0..DEPTH-1, one per cycle, in ascending order, then enter RUN on the cycle after address DEPTH-1 is written. This takes DEPTH cycles.
REQ-022 init_done SHALL be 1 exactly while in RUN; req_ready SHALL be 0 throughout INIT.
REQ-023 Accepted write with req_addr < DEPTH: the FSM SHALL update only the bytes with req_be=1 at the accepting edge; req_be=0 SHALL leave the word unchanged.
REQ-024 Accepted write with req_addr >= DEPTH: memory SHALL be unchanged and wr_err SHALL pulse high in the following cycle.
REQ-025 An accepted read SHALL have its response enter the response buffer exactly RD_LAT cycles after acceptance; rsp_valid SHALL be high the same cycle if the buffer was empty.
REQ-026 Responses SHALL leave the buffer strictly in request order; an entry pops when rsp_valid and rsp_ready are both 1.
REQ-027 A read SHALL return memory contents that include every write accepted in earlier cycles, including a write accepted in the immediately preceding cycle.
REQ-028 Read with req_addr >= DEPTH: the response SHALL have rsp_data=0 and rsp_err=1; otherwise rsp_err=0.
REQ-029 Credit rule: req_ready for a read SHALL be 1 only if (reads in flight + buffer occupancy) < RSP_DEPTH.
REQ-030 Writes SHALL be accepted whenever in RUN; req_ready SHALL equal 1 in RUN when the credit rule holds.
REQ-031 req_ready SHALL also be 1 in RUN when credits are exhausted but req_we=1.
REQ-032 A buffer pop and a new push in the same cycle SHALL keep occupancy unchanged, and no response SHALL be lost.
REQ-033 With rsp_ready held low, the buffer SHALL never overflow; the buffer SHALL hold at most RSP_DEPTH entries.
REQ-034 rsp_data and rsp_err SHALL stay stable while rsp_valid=1 and rsp_ready=0.

Reset
REQ-035 Reset asserted at any time, including mid-INIT, mid-read or with a full buffer, SHALL immediately:
  - drive req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, wr_err=0, init_done=0;
  - discard in-flight reads and buffered responses;
  - restart INIT from address 0 after reset deasserts.
REQ-036 No response to a request accepted before reset SHALL appear after reset.

Verification
REQ-037 Release reset with DEPTH=16 -> init_done rises 16 cycles later; reads of all 16 addresses -> rsp_data=0, rsp_err=0.
REQ-038 Write 0xDEADBEEF to addr 5 with be=0xF, then write 0x000000AA with be=0x1, then read addr 5 back-to-back -> 0xDEADBEAA exactly RD_LAT cycles after the read is accepted.
REQ-039 Read addr 1024 with DEPTH=1024 -> rsp_data=0, rsp_err=1; write addr 2000 -> wr_err pulses for 1 cycle and memory is unchanged.
REQ-040 rsp_ready=0, issue 6 reads with RSP_DEPTH=4 -> only 4 accepted and req_ready=0 after that; raise rsp_ready -> all 6 responses return in order with no loss.
REQ-041 Assert reset mid-INIT and again with 3 buffered responses -> outputs zero immediately, no stale response afterwards, INIT restarts at address 0.
